// File: rtl/rs_issue_scheduler_pkg.sv
// Shared constants and types for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

   localparam int unsigned RSSize     = 16;
   localparam int unsigned RSIdxWidth = $clog2(RSSize);

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   localparam logic ZERO  = 1'b0;

   // Dispatch register state: IDLE means no offer is pending to EX.
   typedef enum logic {
      DISP_IDLE  = 1'b0,
      DISP_OFFER = 1'b1
   } disp_state_e;

endpackage

// File: rtl/rs_issue_scheduler_age_matrix.sv
// rs_age_matrix: RS_SIZE x RS_SIZE relative-age bits. age[j][i]=1 means slot j
// is older than slot i. Produces a one-hot vector of the oldest requester.
module rs_age_matrix #(
   parameter int unsigned RS_SIZE = 16
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               en_in,
   input  logic               flush_in,
   input  logic [RS_SIZE-1:0] alloc_oh_in,
   input  logic [RS_SIZE-1:0] valid_in,
   input  logic [RS_SIZE-1:0] req_in,
   output logic [RS_SIZE-1:0] oldest_oh_out
);

   logic [RS_SIZE-1:0] age_q [RS_SIZE];
   logic [RS_SIZE-1:0] age_d [RS_SIZE];
   logic               older;

   // Next age state: a new slot is younger than every currently valid slot.
   always_comb begin
      for (int unsigned j = 0; j < RS_SIZE; j++) begin
         age_d[j] = age_q[j];
      end
      if (flush_in) begin
         for (int unsigned j = 0; j < RS_SIZE; j++) begin
            age_d[j] = '0;
         end
      end else if (en_in) begin
         for (int unsigned j = 0; j < RS_SIZE; j++) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
               if (alloc_oh_in[i]) begin
                  age_d[j][i] = valid_in[j];
               end
            end
            if (alloc_oh_in[j]) begin
               age_d[j] = '0;
            end
         end
      end
   end

   // Oldest requester: no other requester is marked older than it.
   always_comb begin
      oldest_oh_out = '0;
      older         = 1'b0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         older = 1'b0;
         for (int unsigned j = 0; j < RS_SIZE; j++) begin
            older = older | (req_in[j] & age_q[j][i]);
         end
         oldest_oh_out[i] = req_in[i] & ~older;
      end
   end

   // Age state register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         age_q <= '{default: '0};
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: RS slot allocation and oldest-ready-first dispatch to EX.
// Optional statistics counters are built when RS_SCHED_STATS_EN is defined.
module rs_issue_scheduler
   import rs_issue_scheduler_pkg::*;
#(
   parameter int unsigned RS_SIZE = RSSize,
   parameter int unsigned IDX_W   = RSIdxWidth
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               rdy_in,
   input  logic               clear_branch_in,
   input  logic               alloc_req_in,
   output logic               alloc_gnt_out,
   output logic [IDX_W-1:0]   alloc_idx_out,
   output logic               full_out,
   input  logic [RS_SIZE-1:0] ready_vec_in,
   output logic               disp_valid_out,
   output logic [IDX_W-1:0]   disp_idx_out,
   input  logic               disp_ready_in,
   output logic [RS_SIZE-1:0] busy_vec_out,
   output logic [31:0]        stat_disp_out,
   output logic [31:0]        stat_stall_out
);

   logic [RS_SIZE-1:0] valid_q, valid_d;
   logic [RS_SIZE-1:0] inflight_q, inflight_d;
   disp_state_e        disp_state_q, disp_state_d;
   logic [IDX_W-1:0]   disp_idx_q, disp_idx_d;

   logic [RS_SIZE-1:0] alloc_oh, cand, oldest_oh, disp_oh;
   logic [IDX_W-1:0]   alloc_idx, win_idx;
   logic               full, grant, advance, flush;
   logic               disp_valid, handshake, load;

   // Free-slot search: lowest-index free slot, 0 when full.
   always_comb begin
      alloc_idx = '0;
      for (int unsigned i = RS_SIZE; i > 0; i--) begin
         if (!valid_q[i-1]) begin
            alloc_idx = IDX_W'(i - 1);
         end
      end
   end

   // Control terms shared by allocation and dispatch.
   always_comb begin
      advance    = rdy_in & ~clear_branch_in;
      flush      = rdy_in & clear_branch_in;
      full       = &valid_q;
      grant      = alloc_req_in & ~full & advance;
      alloc_oh   = grant ? (RS_SIZE'(1) << alloc_idx) : '0;
      cand       = valid_q & ~inflight_q & ready_vec_in;
      disp_valid = (disp_state_q == DISP_OFFER);
      disp_oh    = RS_SIZE'(1) << disp_idx_q;
      handshake  = disp_valid & disp_ready_in & rdy_in;
      load       = advance & (~disp_valid | disp_ready_in);
   end

   rs_age_matrix #(
      .RS_SIZE (RS_SIZE)
   ) u_age (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .en_in         (advance),
      .flush_in      (flush),
      .alloc_oh_in   (alloc_oh),
      .valid_in      (valid_q),
      .req_in        (cand),
      .oldest_oh_out (oldest_oh)
   );

   // One-hot winner to slot index.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (oldest_oh[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   // Next slot and dispatch state; everything holds while rdy_in is low.
   always_comb begin
      valid_d      = valid_q;
      inflight_d   = inflight_q;
      disp_state_d = disp_state_q;
      disp_idx_d   = disp_idx_q;
      if (flush) begin
         valid_d      = '0;
         inflight_d   = '0;
         disp_state_d = DISP_IDLE;
      end else if (advance) begin
         valid_d    = (valid_q | alloc_oh) & ~(handshake ? disp_oh : '0);
         inflight_d = inflight_q & ~(handshake ? disp_oh : '0);
         if (load) begin
            inflight_d   = inflight_d | oldest_oh;
            disp_state_d = (|cand) ? DISP_OFFER : DISP_IDLE;
            disp_idx_d   = win_idx;
         end
      end
   end

   // Slot and dispatch registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q      <= '0;
         inflight_q   <= '0;
         disp_state_q <= DISP_IDLE;
         disp_idx_q   <= '0;
      end else begin
         valid_q      <= valid_d;
         inflight_q   <= inflight_d;
         disp_state_q <= disp_state_d;
         disp_idx_q   <= disp_idx_d;
      end
   end

`ifdef RS_SCHED_STATS_EN
   logic [31:0] stat_disp_q, stat_disp_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Counter increments; both wrap naturally at 2^32.
   always_comb begin
      stat_disp_d  = stat_disp_q + (handshake ? 32'd1 : 32'd0);
      stat_stall_d = stat_stall_q +
                     ((disp_valid & ~disp_ready_in & rdy_in) ? 32'd1 : 32'd0);
   end

   // Statistics registers, kept across flushes.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stat_disp_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_disp_q  <= stat_disp_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_disp_out  = stat_disp_q;
   assign stat_stall_out = stat_stall_q;
`else
   assign stat_disp_out  = '0;
   assign stat_stall_out = '0;
`endif

   assign alloc_gnt_out  = grant;
   assign alloc_idx_out  = alloc_idx;
   assign full_out       = full;
   assign disp_valid_out = disp_valid;
   assign disp_idx_out   = disp_idx_q;
   assign busy_vec_out   = valid_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: directed scenarios with literal
// expectations plus randomized traffic against an age-stamp reference model.
module tb_rs_issue_scheduler;

   localparam int N = 16;

   logic        clk_in, rst_n_in, rdy_in, clear_branch_in, alloc_req_in;
   logic        alloc_gnt_out, full_out, disp_valid_out, disp_ready_in;
   logic [3:0]  alloc_idx_out, disp_idx_out;
   logic [15:0] ready_vec_in, busy_vec_out;
   logic [31:0] stat_disp_out, stat_stall_out;

   rs_issue_scheduler #(.RS_SIZE(16), .IDX_W(4)) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .rdy_in          (rdy_in),
      .clear_branch_in (clear_branch_in),
      .alloc_req_in    (alloc_req_in),
      .alloc_gnt_out   (alloc_gnt_out),
      .alloc_idx_out   (alloc_idx_out),
      .full_out        (full_out),
      .ready_vec_in    (ready_vec_in),
      .disp_valid_out  (disp_valid_out),
      .disp_idx_out    (disp_idx_out),
      .disp_ready_in   (disp_ready_in),
      .busy_vec_out    (busy_vec_out),
      .stat_disp_out   (stat_disp_out),
      .stat_stall_out  (stat_stall_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

`ifdef RS_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: each valid slot carries an allocation stamp; oldest = smallest stamp.
   bit          m_valid [N];
   bit          m_infl  [N];
   int unsigned m_seq   [N];
   int unsigned seq_ctr;
   bit          m_dv;
   int          m_di;
   logic [31:0] m_sd, m_ss;

   bit          e_full, e_gnt, e_any;
   int          e_aidx, e_win;
   logic [15:0] e_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_infl[i]  = 1'b0;
         m_seq[i]   = 0;
      end
      m_dv = 1'b0;
      m_di = 0;
      m_sd = '0;
      m_ss = '0;
   endfunction

   function automatic void eval_comb();
      e_full = 1'b1;
      e_aidx = -1;
      for (int i = 0; i < N; i++) begin
         e_busy[i] = m_valid[i];
         if (!m_valid[i]) begin
            e_full = 1'b0;
            if (e_aidx < 0) e_aidx = i;
         end
      end
      if (e_aidx < 0) e_aidx = 0;
      e_gnt = alloc_req_in && !e_full && rdy_in && !clear_branch_in;
      e_any = 1'b0;
      e_win = 0;
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] && !m_infl[i] && ready_vec_in[i]) begin
            if (!e_any || m_seq[i] < m_seq[e_win]) e_win = i;
            e_any = 1'b1;
         end
      end
   endfunction

   function automatic void model_step();
      bit hs, ld;
      eval_comb();
      if (!rdy_in) return;
      if (m_dv && disp_ready_in) m_sd++;
      if (m_dv && !disp_ready_in) m_ss++;
      if (clear_branch_in) begin
         for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_infl[i]  = 1'b0;
         end
         m_dv = 1'b0;
         return;
      end
      hs = m_dv && disp_ready_in;
      ld = !m_dv || disp_ready_in;
      if (e_gnt) begin
         m_valid[e_aidx] = 1'b1;
         m_infl[e_aidx]  = 1'b0;
         m_seq[e_aidx]   = seq_ctr;
         seq_ctr++;
      end
      if (hs) begin
         m_valid[m_di] = 1'b0;
         m_infl[m_di]  = 1'b0;
      end
      if (ld) begin
         m_dv = e_any;
         if (e_any) begin
            m_di = e_win;
            m_infl[e_win] = 1'b1;
         end
      end
   endfunction

   // Compare every observable output against the model.
   task automatic compare();
      eval_comb();
      chk("full", full_out, e_full);
      chk("alloc_gnt", alloc_gnt_out, e_gnt);
      chk("alloc_idx", alloc_idx_out, e_aidx);
      chk("disp_valid", disp_valid_out, m_dv);
      if (m_dv) chk("disp_idx", disp_idx_out, m_di);
      chk("busy_vec", busy_vec_out, e_busy);
      chk("stat_disp", stat_disp_out, STATS ? m_sd : 32'd0);
      chk("stat_stall", stat_stall_out, STATS ? m_ss : 32'd0);
   endtask

   task automatic drive(input logic rq, input logic [15:0] rv, input logic dr,
                        input logic cl, input logic rd);
      alloc_req_in    = rq;
      ready_vec_in    = rv;
      disp_ready_in   = dr;
      clear_branch_in = cl;
      rdy_in          = rd;
      #3;
      compare();
   endtask

   task automatic tick();
      @(posedge clk_in);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n_in        = 1'b0;
      alloc_req_in    = 1'b0;
      ready_vec_in    = '0;
      disp_ready_in   = 1'b0;
      clear_branch_in = 1'b0;
      rdy_in          = 1'b1;
      model_reset();
      #2;
      chk("rst_disp_valid", disp_valid_out, 1'b0);
      chk("rst_disp_idx", disp_idx_out, 4'd0);
      chk("rst_busy", busy_vec_out, 16'h0000);
      chk("rst_stat_disp", stat_disp_out, 32'd0);
      chk("rst_stat_stall", stat_stall_out, 32'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;
   endtask

   task automatic alloc_n(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
         tick();
      end
   endtask

   initial begin
      rst_n_in = 1'b0;
      seq_ctr  = 0;

      // 1: three allocations take slots 0,1,2.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
         chk("t1_alloc_idx", alloc_idx_out, i);
         tick();
      end
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("t1_busy", busy_vec_out, 16'h0007);
      tick();

      // 2: oldest-first ordering, including a reallocated (youngest) slot 0.
      do_reset();
      alloc_n(4);
      drive(1'b0, 16'h000C, 1'b1, 1'b0, 1'b1);
      chk("t2_first_offer_latency", disp_valid_out, 1'b0);
      tick();
      drive(1'b0, 16'h000C, 1'b1, 1'b0, 1'b1);
      chk("t2_idx2", disp_idx_out, 4'd2);
      tick();
      drive(1'b0, 16'h000C, 1'b1, 1'b0, 1'b1);
      chk("t2_idx3", disp_idx_out, 4'd3);
      tick();
      drive(1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
      chk("t2_realloc2", alloc_idx_out, 4'd2);
      tick();
      drive(1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
      chk("t2_realloc3", alloc_idx_out, 4'd3);
      tick();
      drive(1'b0, 16'h0001, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      chk("t2_idx0_free", disp_idx_out, 4'd0);
      tick();
      drive(1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
      chk("t2_realloc0", alloc_idx_out, 4'd0);
      tick();
      drive(1'b0, 16'h000D, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b0, 16'h000D, 1'b1, 1'b0, 1'b1);
      chk("t2_order_a", disp_idx_out, 4'd2);
      tick();
      drive(1'b0, 16'h000D, 1'b1, 1'b0, 1'b1);
      chk("t2_order_b", disp_idx_out, 4'd3);
      tick();
      drive(1'b0, 16'h000D, 1'b1, 1'b0, 1'b1);
      chk("t2_order_c", disp_idx_out, 4'd0);
      tick();

      // 3: backpressure holds slot 5 stable, then acceptance frees it.
      do_reset();
      alloc_n(6);
      drive(1'b0, 16'h0020, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 16'h0020, 1'b0, 1'b0, 1'b1);
         chk("t3_hold_idx", disp_idx_out, 4'd5);
         tick();
      end
      drive(1'b0, 16'h0020, 1'b1, 1'b0, 1'b1);
      chk("t3_hold_valid", disp_valid_out, 1'b1);
`ifdef RS_SCHED_STATS_EN
      chk("t3_stall4", stat_stall_out, 32'd4);
`endif
      tick();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("t3_freed5", busy_vec_out, 16'h001F);
`ifdef RS_SCHED_STATS_EN
      chk("t3_disp1", stat_disp_out, 32'd1);
`endif
      tick();

      // 4: full RS refuses allocation until slot 7 leaves.
      do_reset();
      alloc_n(16);
      drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("t4_full", full_out, 1'b1);
      chk("t4_no_gnt", alloc_gnt_out, 1'b0);
      tick();
      drive(1'b0, 16'h0080, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 16'h0080, 1'b1, 1'b0, 1'b1);
      chk("t4_offer7", disp_idx_out, 4'd7);
      chk("t4_still_full_gnt", alloc_gnt_out, 1'b0);
      tick();
      drive(1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
      chk("t4_realloc7", alloc_idx_out, 4'd7);
      chk("t4_gnt", alloc_gnt_out, 1'b1);
      tick();

      // 5: flush with a pending offer.
      do_reset();
      alloc_n(6);
      drive(1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("t5_flush_no_gnt", alloc_gnt_out, 1'b0);
      chk("t5_pending", disp_valid_out, 1'b1);
      tick();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("t5_busy0", busy_vec_out, 16'h0000);
      chk("t5_dv0", disp_valid_out, 1'b0);
      tick();

      // 6: rdy_in low freezes everything, then async reset mid-offer.
      do_reset();
      alloc_n(2);
      drive(1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         chk("t6_frz_dv", disp_valid_out, 1'b1);
         chk("t6_frz_idx", disp_idx_out, 4'd1);
         chk("t6_frz_busy", busy_vec_out, 16'h0003);
         chk("t6_frz_gnt", alloc_gnt_out, 1'b0);
         tick();
      end
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("t6_after_dv", disp_valid_out, 1'b1);
      #1;
      rst_n_in = 1'b0;
      #1;
      chk("t6_async_dv", disp_valid_out, 1'b0);
      chk("t6_async_busy", busy_vec_out, 16'h0000);
      model_reset();
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         int aprob;
         aprob = (c < 1500) ? 6 : 3;
         drive(1'($urandom_range(0, 9) < aprob), 16'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
               1'($urandom_range(0, 9) != 0));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
